// File: rtl/bg_color_estimator_if.sv
// Sum-word handshake between the processing elements and the background estimator.
// One word carries three channel sums plus the pixel count they cover.
interface bg_color_estimator_if #(
  parameter int SUM_W = 16
);
  logic             sum_valid;
  logic             sum_ready;
  logic [SUM_W-1:0] red_sum_in;
  logic [SUM_W-1:0] green_sum_in;
  logic [SUM_W-1:0] blue_sum_in;
  logic [7:0]       count_in;

  modport master (
    output sum_valid, red_sum_in, green_sum_in, blue_sum_in, count_in,
    input  sum_ready
  );

  modport slave (
    input  sum_valid, red_sum_in, green_sum_in, blue_sum_in, count_in,
    output sum_ready
  );
endinterface

// File: rtl/bg_color_estimator.sv
// Accumulates NUM_PE channel-sum words, then divides each channel total by the
// pixel total (restoring, one bit per cycle) to give the expected background colour.
//
// state | meaning
// IDLE  | waiting for Start, previous result held
// ACC   | accepting sum words until NUM_PE have arrived
// DIV   | shift-subtract divide, ACC_W cycles (one cycle if pixel total is 0)
// DONE  | result valid, waiting for Ack
module bg_color_estimator #(
  parameter int NUM_PE = 4,
  parameter int SUM_W  = 16,
  parameter int ACC_W  = 24
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        Ack,
  bg_color_estimator_if.slave         sum_bus,
  output logic [8:0]                  red_exp,
  output logic [8:0]                  green_exp,
  output logic [8:0]                  blue_exp,
  output logic                        Done,
  output logic                        Qi,
  output logic                        Qacc,
  output logic                        Qdiv,
  output logic                        Qd
);
  localparam int CNT_W  = $clog2(NUM_PE + 1);
  localparam int DCNT_W = $clog2(ACC_W);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ACC  = 4'b0010,
    S_DIV  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t state, state_n;

  // acc doubles as dividend/quotient shift register during DIV
  logic [ACC_W-1:0] acc     [3];
  logic [ACC_W-1:0] rem     [3];
  logic [ACC_W-1:0] quo_n   [3];
  logic [ACC_W-1:0] rem_n   [3];
  logic [ACC_W:0]   shifted [3];
  logic [SUM_W-1:0] sum_in  [3];
  logic [8:0]       exp_q   [3];
  logic [15:0]      pix_total;
  logic [CNT_W-1:0] word_cnt;
  logic [DCNT_W-1:0] div_cnt;
  logic [ACC_W:0]   divisor;
  logic             accept;
  logic             last_word;

  function automatic logic [8:0] sat8(input logic [ACC_W-1:0] q);
    if (q > ACC_W'(255)) return 9'd255;
    return {1'b0, q[7:0]};
  endfunction

  assign sum_in[0] = sum_bus.red_sum_in;
  assign sum_in[1] = sum_bus.green_sum_in;
  assign sum_in[2] = sum_bus.blue_sum_in;

  assign accept    = (state == S_ACC) && sum_bus.sum_valid;
  assign last_word = accept && (word_cnt == CNT_W'(NUM_PE - 1));
  assign divisor   = {{(ACC_W + 1 - 16){1'b0}}, pix_total};

  assign sum_bus.sum_ready   = (state == S_ACC);
  assign Done                = (state == S_DONE);
  assign {Qd, Qdiv, Qacc, Qi} = state;
  assign red_exp             = exp_q[0];
  assign green_exp           = exp_q[1];
  assign blue_exp            = exp_q[2];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      shifted[i] = {rem[i], acc[i][ACC_W-1]};
      rem_n[i]   = shifted[i][ACC_W-1:0];
      quo_n[i]   = {acc[i][ACC_W-2:0], 1'b0};
      if (shifted[i] >= divisor) begin
        rem_n[i] = ACC_W'(shifted[i] - divisor);
        quo_n[i] = {acc[i][ACC_W-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (Start) state_n = S_ACC;
      S_ACC:  if (last_word) state_n = S_DIV;
      S_DIV:  if (pix_total == 16'd0 || div_cnt == '0) state_n = S_DONE;
      S_DONE: if (Ack) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 3; i++) begin
        acc[i]   <= '0;
        rem[i]   <= '0;
        exp_q[i] <= '0;
      end
      pix_total <= '0;
      word_cnt  <= '0;
      div_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            for (int i = 0; i < 3; i++) begin
              acc[i] <= '0;
              rem[i] <= '0;
            end
            pix_total <= '0;
            word_cnt  <= '0;
          end
        end
        S_ACC: begin
          if (accept) begin
            for (int i = 0; i < 3; i++) acc[i] <= acc[i] + ACC_W'(sum_in[i]);
            pix_total <= pix_total + 16'(sum_bus.count_in);
            word_cnt  <= word_cnt + CNT_W'(1);
          end
          if (last_word) div_cnt <= DCNT_W'(ACC_W - 1);
        end
        S_DIV: begin
          div_cnt <= div_cnt - DCNT_W'(1);
          for (int i = 0; i < 3; i++) begin
            acc[i] <= quo_n[i];
            rem[i] <= rem_n[i];
          end
          if (state_n == S_DONE) begin
            for (int i = 0; i < 3; i++)
              exp_q[i] <= (pix_total == 16'd0) ? 9'd0 : sat8(quo_n[i]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bg_color_estimator.sv
// Directed plus randomized checks of bg_color_estimator against an arithmetic
// model: expected colour = min(255, channel total / pixel total), 0 if no pixels.
module tb_bg_color_estimator;
  localparam int NUM_PE = 4;
  localparam int SUM_W  = 16;
  localparam int ACC_W  = 24;

  logic       Clk = 1'b0;
  logic       Reset, Start, Ack;
  logic [8:0] red_exp, green_exp, blue_exp;
  logic       Done, Qi, Qacc, Qdiv, Qd;

  bg_color_estimator_if #(.SUM_W(SUM_W)) sum_bus ();

  bg_color_estimator #(.NUM_PE(NUM_PE), .SUM_W(SUM_W), .ACC_W(ACC_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .sum_bus   (sum_bus),
    .red_exp   (red_exp),
    .green_exp (green_exp),
    .blue_exp  (blue_exp),
    .Done      (Done),
    .Qi        (Qi),
    .Qacc      (Qacc),
    .Qdiv      (Qdiv),
    .Qd        (Qd)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned w_r [NUM_PE];
  int unsigned w_g [NUM_PE];
  int unsigned w_b [NUM_PE];
  int unsigned w_c [NUM_PE];
  bit gaps, noise;

  longint pix_m;
  int exp_r, exp_g, exp_b;
  int last_r = 0, last_g = 0, last_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int colour(input longint total, input longint pix);
    longint q;
    if (pix == 0) return 0;
    q = total / pix;
    return (q > 255) ? 255 : int'(q);
  endfunction

  task automatic compute_model();
    longint tr = 0, tg = 0, tb = 0;
    pix_m = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      tr += w_r[i]; tg += w_g[i]; tb += w_b[i]; pix_m += w_c[i];
    end
    exp_r = colour(tr, pix_m);
    exp_g = colour(tg, pix_m);
    exp_b = colour(tb, pix_m);
  endtask

  task automatic start_and_feed(output int edges);
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    edges = 1;
    check("acc_entry", 32'(Qacc), 32'd1);
    for (int i = 0; i < NUM_PE; i++) begin
      if (gaps) begin
        sum_bus.sum_valid = 1'b0;
        if (noise) Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        edges++;
      end
      sum_bus.sum_valid    = 1'b1;
      sum_bus.red_sum_in   = w_r[i][SUM_W-1:0];
      sum_bus.green_sum_in = w_g[i][SUM_W-1:0];
      sum_bus.blue_sum_in  = w_b[i][SUM_W-1:0];
      sum_bus.count_in     = w_c[i][7:0];
      check("ready_in_acc", 32'(sum_bus.sum_ready), 32'd1);
      @(negedge Clk);
      edges++;
    end
    sum_bus.sum_valid = 1'b0;
    check("ready_low_after_last", 32'(sum_bus.sum_ready), 32'd0);
    check("div_entry", 32'(Qdiv), 32'd1);
  endtask

  task automatic finish_and_check(input int edges_acc);
    int edges = edges_acc;
    bit got = 1'b0;
    for (int c = 0; c < ACC_W + 20; c++) begin
      if (noise && c == 2) Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      edges++;
      if (Done) begin
        got = 1'b1;
        break;
      end
      check("exp_held_div", 32'(red_exp), 32'(last_r));
    end
    if (!got) check("done_timeout", 32'(Done), 32'd1);
    else check("latency", 32'(edges), 32'(edges_acc + ((pix_m == 0) ? 1 : ACC_W)));
    check("qd_flag", 32'(Qd), 32'd1);
    check("red_exp", 32'(red_exp), 32'(exp_r));
    check("green_exp", 32'(green_exp), 32'(exp_g));
    check("blue_exp", 32'(blue_exp), 32'(exp_b));
    last_r = exp_r; last_g = exp_g; last_b = exp_b;
  endtask

  task automatic do_ack(input int hold, input bit with_start);
    for (int c = 0; c < hold; c++) begin
      @(negedge Clk);
      check("done_hold", 32'(Done), 32'd1);
      check("red_hold", 32'(red_exp), 32'(last_r));
    end
    Ack = 1'b1;
    Start = with_start;
    @(negedge Clk);
    Ack = 1'b0;
    Start = 1'b0;
    check("ack_to_idle", 32'(Qi), 32'd1);
    check("done_low_idle", 32'(Done), 32'd0);
    check("red_kept_idle", 32'(red_exp), 32'(last_r));
    check("blue_kept_idle", 32'(blue_exp), 32'(last_b));
  endtask

  task automatic run_full(input int hold);
    int edges;
    compute_model();
    start_and_feed(edges);
    finish_and_check(edges);
    do_ack(hold, 1'b0);
  endtask

  task automatic set_words(input int unsigned r, input int unsigned g, input int unsigned b,
                           input int unsigned c);
    for (int i = 0; i < NUM_PE; i++) begin
      w_r[i] = r; w_g[i] = g; w_b[i] = b; w_c[i] = c;
    end
  endtask

  initial begin
    int edges;
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0;
    sum_bus.sum_valid = 1'b0;
    sum_bus.red_sum_in = '0; sum_bus.green_sum_in = '0; sum_bus.blue_sum_in = '0;
    sum_bus.count_in = '0;
    gaps = 1'b0; noise = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_qi", 32'(Qi), 32'd1);
    check("rst_flags", 32'({Qd, Qdiv, Qacc}), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_ready", 32'(sum_bus.sum_ready), 32'd0);
    check("rst_exp", 32'({red_exp, green_exp, blue_exp}), 32'd0);
    Reset = 1'b0;

    // uniform colour, back-to-back words
    set_words(61, 133, 198, 1);
    run_full(0);

    // truncation
    set_words(10, 0, 7, 1);
    w_r[3] = 11; w_g[3] = 3;
    run_full(1);

    // zero pixel total
    set_words(500, 600, 700, 0);
    run_full(0);

    // gaps plus ignored Start pulses
    set_words(0, 0, 0, 2);
    w_r[0] = 100; w_r[1] = 200; w_r[2] = 50; w_r[3] = 50;
    w_g[0] = 90;  w_g[1] = 17;  w_b[2] = 333;
    gaps = 1'b1; noise = 1'b1;
    run_full(0);
    gaps = 1'b0; noise = 1'b0;

    // reset in the middle of the divide
    set_words(61, 133, 198, 1);
    compute_model();
    start_and_feed(edges);
    repeat (10) @(negedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("midrst_qi", 32'(Qi), 32'd1);
    check("midrst_qdiv", 32'(Qdiv), 32'd0);
    check("midrst_exp", 32'({red_exp, green_exp, blue_exp}), 32'd0);
    check("midrst_ready", 32'(sum_bus.sum_ready), 32'd0);
    last_r = 0; last_g = 0; last_b = 0;
    @(negedge Clk);
    Reset = 1'b0;
    run_full(0);

    // saturation, long Ack hold, Start together with Ack
    set_words(0, 0, 0, 1);
    w_r[0] = 4000;
    compute_model();
    start_and_feed(edges);
    finish_and_check(edges);
    do_ack(5, 1'b1);
    @(negedge Clk);
    check("start_with_ack_ignored", 32'(Qi), 32'd1);

    // randomized estimates
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NUM_PE; i++) begin
        w_r[i] = $urandom_range(0, 65535);
        w_g[i] = $urandom_range(0, 65535);
        w_b[i] = $urandom_range(0, 65535);
        w_c[i] = (k % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
        if (k == 5) w_c[i] = 0;
      end
      gaps  = 1'($urandom_range(0, 1));
      noise = gaps;
      run_full(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bg_color_estimator.md
Name: bg_color_estimator

Overview:
- Downstream consumer of the processing-element sum outputs: collects per-channel red/green/blue sums and pixel counts from NUM_PE elements, one word per handshake.
- Divides each channel total by the total pixel count to produce the expected background colour (red_exp, green_exp, blue_exp).
- These outputs feed the processing elements' background-removal pass.
- Multi-cycle: accumulate phase, then a sequential restoring divider, then a held result with Ack handshake.

Parameters:
NUM_PE, 4, number of sum words accepted per estimate (one per processing element)
SUM_W, 16, width of each incoming channel sum
ACC_W, 24, accumulator/divider width; must be >= SUM_W + ceil(log2(NUM_PE)); also sets divide latency

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  begin a new estimate; sampled only in IDLE
Ack  input  1  result consumed; sampled only in DONE
sum_valid  input  1  sum word present on *_sum_in and count_in
sum_ready  output  1  block accepts a sum word this cycle
red_sum_in  input  SUM_W  red channel sum from one element
green_sum_in  input  SUM_W  green channel sum
blue_sum_in  input  SUM_W  blue channel sum
count_in  input  8  number of pixels covered by this word
red_exp  output  9  expected background red, 0..255
green_exp  output  9  expected background green
blue_exp  output  9  expected background blue
Done  output  1  result valid, high in DONE
Qi, Qacc, Qdiv, Qd  output  1 each  one-hot state flags

Behaviour:
- Reset (async, any state, including mid-accumulate or mid-divide):
  - state IDLE; accumulators, pixel count, word counter, quotients cleared.
  - red_exp, green_exp, blue_exp = 0; Done = 0; sum_ready = 0; Qi = 1, others 0.
- State encoding is one-hot {Qd, Qdiv, Qacc, Qi}.
- IDLE:
  - Start = 1 -> ACC next edge; clears three ACC_W accumulators, the 16-bit pixel total and the word counter.
  - Otherwise stay. Previous *_exp values stay held.
- ACC:
  - sum_ready = 1 for the whole state.
  - On each edge with sum_valid = 1: each accumulator += zero-extended channel sum; pixel total += count_in; word counter += 1.
  - When the NUM_PE-th word is accepted -> DIV next edge. sum_ready is low from that edge on.
  - Gaps (sum_valid = 0) are allowed indefinitely; there is no timeout.
  - Start is ignored. Accumulator overflow wraps; ACC_W sizing makes it unreachable for legal inputs.
- DIV:
  - Restoring shift-subtract divider; all three channels run in parallel against the shared pixel total.
  - One quotient bit per cycle, MSB first; exactly ACC_W cycles; then -> DONE.
  - Truncating division, no rounding.
  - Result per channel: quotient saturated to 255 if larger, zero-extended to 9 bits.
  - Pixel total = 0: skip the divide, result 0 for all channels, enter DONE on the next edge.
  - *_exp update only on the DONE-entry edge and hold the old value throughout DIV.
  - Start is ignored.
- DONE:
  - Done = 1, *_exp stable.
  - Ack = 1 -> IDLE next edge; *_exp keep their value in IDLE.
  - Start is ignored in DONE, even if asserted together with Ack.
- Latency: Start edge, then 1 cycle to ACC, NUM_PE accept cycles minimum, then ACC_W cycles in DIV, then DONE. Default minimum is 1 + 4 + 24 = 29 edges from Start sample to Done high.

Test Plan:
1. Reset, then Start; 4 words each red=61, green=133, blue=198, count=1, sum_valid held high -> Done after 29 edges; red_exp=61, green_exp=133, blue_exp=198; sum_ready low after 4th word.
2. Red sums 10, 10, 10, 11, count=1 each -> red_exp=10 (41/4 truncated). Green sums 0, 0, 0, 3 -> green_exp=0.
3. Every count_in=0 -> Done one edge after the 4th accept; all *_exp=0.
4. sum_valid toggling every other cycle, with red sums 100, 200, 50, 50 and counts 2, 2, 2, 2 -> only valid cycles accumulate; red_exp=50. Start pulsed during ACC and DIV -> no effect.
5. Reset asserted on DIV cycle 10 -> all outputs 0 and Qi=1 immediately. New Start with case-1 data -> identical result.
6. Red sum 4000 in word 1, other red sums 0, counts 1, 1, 1, 1 -> red_exp saturates to 255. Hold Ack low 5 cycles -> Done and values stable. Ack -> IDLE with red_exp still 255.
